counter_table_decay: RTL and testbench

COUNTER_TABLE_DECAY -- requirements
Module: counter_table_decay

---
 rtl/counter_table_decay.sv | 133 +++++++++++++
 tb/tb_counter_table_decay.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_table_decay.sv
// Table of saturating counters with two registered read ports and a background halving sweep.
// Optional macro COUNTER_BYPASS_EN: same-cycle reads return the post-write value instead of read-first.
module counter_table_decay #(
    parameter int COUNTERWIDE = 2,
    parameter int COUNTERPW   = 5,
    parameter int COUNTERDEEP = 32
) (
    input  logic                   Clk,
    input  logic                   Rest,
    input  logic                   UpdateAble,
    input  logic [COUNTERPW-1:0]   UpAddr,
    input  logic                   RightOrFault,
    input  logic                   ReadAbleA,
    input  logic [COUNTERPW-1:0]   ReadAddrA,
    input  logic                   ReadAbleB,
    input  logic [COUNTERPW-1:0]   ReadAddrB,
    input  logic                   Attenuation,
    output logic [COUNTERWIDE-1:0] DoutCounterA,
    output logic [COUNTERWIDE-1:0] DoutCounterB,
    output logic                   DecayBusy
);

    localparam logic [COUNTERWIDE-1:0] MAXV     = '1;
    localparam logic [COUNTERPW:0]     DEEP_X   = (COUNTERPW+1)'(COUNTERDEEP);
    localparam logic [COUNTERPW-1:0]   LAST_IDX = COUNTERPW'(COUNTERDEEP - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                 state_q;
    logic [COUNTERPW-1:0]   sw_idx_q;
    logic                   busy_q;

    logic [COUNTERWIDE-1:0] table_q [COUNTERDEEP];
    logic [COUNTERWIDE-1:0] table_d [COUNTERDEEP];
    logic [COUNTERWIDE-1:0] dout_a_q, dout_a_d;
    logic [COUNTERWIDE-1:0] dout_b_q, dout_b_d;

    function automatic logic in_range(input logic [COUNTERPW-1:0] addr);
        return {1'b0, addr} < DEEP_X;
    endfunction

    function automatic logic [COUNTERWIDE-1:0] sat_step(input logic [COUNTERWIDE-1:0] v,
                                                        input logic                   up);
        if (up)
            return (v == MAXV) ? v : v + 1'b1;
        else
            return (v == '0) ? v : v - 1'b1;
    endfunction

    // Halving is applied first so a colliding update acts on the decayed value.
    always_comb begin
        logic [COUNTERWIDE-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < COUNTERDEEP; i++) begin
            v = table_q[i];
            if (state_q == SWEEP && sw_idx_q == COUNTERPW'(i))
                v = v >> 1;
            if (UpdateAble && UpAddr == COUNTERPW'(i))
                v = sat_step(v, RightOrFault);
            table_d[i] = v;
        end
    end

    always_comb begin
        dout_a_d = '0;
        dout_b_d = '0;
`ifdef COUNTER_BYPASS_EN
        if (ReadAbleA && in_range(ReadAddrA))
            dout_a_d = table_d[ReadAddrA];
        if (ReadAbleB && in_range(ReadAddrB))
            dout_b_d = table_d[ReadAddrB];
`else
        if (ReadAbleA && in_range(ReadAddrA))
            dout_a_d = table_q[ReadAddrA];
        if (ReadAbleB && in_range(ReadAddrB))
            dout_b_d = table_q[ReadAddrB];
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            for (int unsigned i = 0; i < COUNTERDEEP; i++)
                table_q[i] <= '0;
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            for (int unsigned i = 0; i < COUNTERDEEP; i++)
                table_q[i] <= table_d[i];
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q  <= IDLE;
            sw_idx_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Attenuation) begin
                        state_q  <= SWEEP;
                        sw_idx_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sw_idx_q == LAST_IDX) begin
                        state_q  <= IDLE;
                        sw_idx_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        sw_idx_q <= sw_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    sw_idx_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign DoutCounterA = dout_a_q;
    assign DoutCounterB = dout_b_q;
    assign DecayBusy    = busy_q;

endmodule

// File: tb/tb_counter_table_decay.sv
// Randomised and directed bench for counter_table_decay against a behavioural table model.
module tb_counter_table_decay;

    localparam int W    = 2;
    localparam int PW   = 5;
    localparam int DEEP = 32;
    localparam int MAXV = (1 << W) - 1;
`ifdef COUNTER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rest, UpdateAble, RightOrFault, ReadAbleA, ReadAbleB, Attenuation;
    logic [PW-1:0] UpAddr, ReadAddrA, ReadAddrB;
    logic [W-1:0]  DoutCounterA, DoutCounterB;
    logic          DecayBusy;

    int m_mem [DEEP];
    int m_busy, m_idx, m_da, m_db;
    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;

    counter_table_decay #(
        .COUNTERWIDE(W),
        .COUNTERPW  (PW),
        .COUNTERDEEP(DEEP)
    ) dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .UpdateAble  (UpdateAble),
        .UpAddr      (UpAddr),
        .RightOrFault(RightOrFault),
        .ReadAbleA   (ReadAbleA),
        .ReadAddrA   (ReadAddrA),
        .ReadAbleB   (ReadAbleB),
        .ReadAddrB   (ReadAddrB),
        .Attenuation (Attenuation),
        .DoutCounterA(DoutCounterA),
        .DoutCounterB(DoutCounterB),
        .DecayBusy   (DecayBusy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Rest = 1'b0; UpdateAble = 1'b0; RightOrFault = 1'b0; UpAddr = '0;
        ReadAbleA = 1'b0; ReadAddrA = '0; ReadAbleB = 1'b0; ReadAddrB = '0;
        Attenuation = 1'b0;
    endtask

    // Table behaviour for one clock edge given the current inputs.
    task automatic model_edge();
        int pre [DEEP];
        int post [DEEP];
        int a;
        if (Rest) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_busy = 0; m_idx = 0; m_da = 0; m_db = 0;
            return;
        end
        pre  = m_mem;
        post = m_mem;
        if (m_busy != 0)
            post[m_idx] = pre[m_idx] / 2;
        a = int'(UpAddr);
        if (UpdateAble && a < DEEP) begin
            if (RightOrFault) post[a] = (post[a] < MAXV) ? post[a] + 1 : MAXV;
            else              post[a] = (post[a] > 0) ? post[a] - 1 : 0;
        end
        a = int'(ReadAddrA);
        m_da = (ReadAbleA && a < DEEP) ? (BYP ? post[a] : pre[a]) : 0;
        a = int'(ReadAddrB);
        m_db = (ReadAbleB && a < DEEP) ? (BYP ? post[a] : pre[a]) : 0;
        if (m_busy != 0) begin
            if (m_idx == DEEP - 1) begin m_busy = 0; m_idx = 0; end
            else m_idx++;
        end else if (Attenuation) begin
            m_busy = 1; m_idx = 0;
        end
        m_mem = post;
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check("doutA", int'(DoutCounterA), m_da);
        check("doutB", int'(DoutCounterB), m_db);
        check("busy",  int'(DecayBusy),    m_busy);
        if (DecayBusy) busy_cnt++;
        idle_inputs();
    endtask

    task automatic update(input int addr, input bit up);
        UpdateAble = 1'b1; UpAddr = PW'(addr); RightOrFault = up;
        step();
    endtask

    task automatic read_ab(input int addr_a, input int addr_b);
        ReadAbleA = 1'b1; ReadAddrA = PW'(addr_a);
        ReadAbleB = 1'b1; ReadAddrB = PW'(addr_b);
        step();
    endtask

    initial begin
        idle_inputs();
        busy_cnt = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        m_busy = 0; m_idx = 0; m_da = 0; m_db = 0;

        Rest = 1'b1; step();
        Rest = 1'b1; step();
        check("rst_busy", int'(DecayBusy), 0);
        check("rst_doutA", int'(DoutCounterA), 0);

        // Saturation at the top.
        for (int k = 0; k < 4; k++) update(5, 1'b1);
        read_ab(5, 5);
        check("sat_top", int'(DoutCounterA), 3);

        // No underflow; disabled read port returns zero.
        update(7, 1'b0);
        read_ab(7, 0);
        check("sat_bottom", int'(DoutCounterA), 0);
        for (int k = 0; k < 3; k++) update(7, 1'b1);
        ReadAbleA = 1'b0; ReadAddrA = PW'(7); ReadAbleB = 1'b1; ReadAddrB = PW'(7);
        step();
        check("rd_disabled", int'(DoutCounterA), 0);
        check("rd_enabled_b", int'(DoutCounterB), 3);

        // Full table at MAX, then one sweep with a second pulse mid-sweep.
        for (int e = 0; e < DEEP; e++)
            for (int k = 0; k < 4; k++)
                if (m_mem[e] < MAXV) update(e, 1'b1);
        busy_cnt = 0;
        Attenuation = 1'b1; step();
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) Attenuation = 1'b1;
            step();
        end
        check("sweep_len", busy_cnt, DEEP);
        for (int e = 0; e < DEEP; e += 2) begin
            read_ab(e, e + 1);
            check("halved_a", int'(DoutCounterA), 1);
            check("halved_b", int'(DoutCounterB), 1);
        end

        // Update colliding with the sweep index, and update ahead of the sweep.
        update(4, 1'b1);
        update(20, 1'b1);
        Attenuation = 1'b1; step();
        for (int k = 0; k < 40 && m_idx != 4; k++) step();
        update(4, 1'b1);
        update(20, 1'b1);
        for (int k = 0; k < 40 && m_busy != 0; k++) step();
        read_ab(4, 20);
        check("collide_4", int'(DoutCounterA), 2);
        check("ahead_20", int'(DoutCounterB), 1);

        // Same-cycle write and read of one entry.
        for (int k = 0; k < 4 && m_mem[9] != 1; k++) update(9, m_mem[9] < 1);
        UpdateAble = 1'b1; UpAddr = PW'(9); RightOrFault = 1'b1;
        ReadAbleA = 1'b1; ReadAddrA = PW'(9);
        step();
        check("same_cycle", int'(DoutCounterA), BYP ? 2 : 1);
        read_ab(0, 9);
        check("next_cycle", int'(DoutCounterB), 2);

        // Reset aborts a sweep in progress.
        for (int e = 0; e < DEEP; e++) if (m_mem[e] < MAXV) update(e, 1'b1);
        Attenuation = 1'b1; step();
        for (int k = 0; k < 40 && m_idx != 15; k++) step();
        Rest = 1'b1; ReadAbleA = 1'b1; ReadAddrA = PW'(3); step();
        check("abort_busy", int'(DecayBusy), 0);
        check("abort_doutA", int'(DoutCounterA), 0);
        for (int e = 0; e < DEEP; e += 2) begin
            read_ab(e, e + 1);
            check("post_rst_a", int'(DoutCounterA), 0);
            check("post_rst_b", int'(DoutCounterB), 0);
        end

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            Rest         = ($urandom_range(0, 299) == 0);
            UpdateAble   = $urandom_range(0, 1);
            UpAddr       = PW'($urandom);
            RightOrFault = ($urandom_range(0, 2) != 0);
            ReadAbleA    = ($urandom_range(0, 3) != 0);
            ReadAddrA    = PW'($urandom);
            ReadAbleB    = ($urandom_range(0, 3) != 0);
            ReadAddrB    = ($urandom_range(0, 3) == 0) ? UpAddr : PW'($urandom);
            Attenuation  = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
